uart_tx: RTL and testbench

- Serial UART transmitter: 8N1 frames, LSB first, fixed number of clocks per bit.
- Counterpart to the uart_rx receiver. Loopback benches wire Tx straight to the receiver's Rx.
- A parallel byte is accepted through a ready/start handshake and shifted out on a registered Tx line. Frame end is reported with a one-cycle done pulse.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : serial UART transmitter, 8N1 frames, LSB first.
//
// A byte is accepted through a ready/start handshake and shifted out on a
// registered Tx line with a fixed number of clocks per bit. The end of each
// frame is flagged with a one-cycle T_done pulse in the first idle cycle.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   CNT_W         width of the bit-period counter (2^CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   T_start  in   request to send, sampled only while T_rdy=1
//   data     in   byte to send, sampled in the accept cycle only
//   T_rdy    out  idle and able to accept a byte
//   T_busy   out  frame in progress (complement of T_rdy)
//   T_done   out  one-cycle pulse after the stop bit completes
//   Tx       out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       T_start,
  input  logic [7:0] data,
  output logic       T_rdy,
  output logic       T_busy,
  output logic       T_done,
  output logic       Tx
);

  // PARITY keeps its code even when the parity feature is compiled out.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // State register. Tx and T_done are registered here too, so the line
  // level for a bit is decided one edge ahead, when that bit is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. The counter restarts at every bit boundary; each
  // transition also loads the Tx level of the bit being entered, so Tx only
  // ever moves on a bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (T_start) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign T_rdy  = (state_q == IDLE);
  assign T_busy = ~T_rdy;
  assign T_done = done_q;
  assign Tx     = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx (CLKS_PER_BIT=4, 100 ns clk).
// Bytes are pushed to a scoreboard queue when sent; an independent line
// monitor decodes each frame cycle by cycle and compares it to the queue.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
  localparam int EXP_FRAMES = 7;
`else
  localparam int NBITS      = 10;
  localparam int EXP_FRAMES = 5;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       T_start;
  logic [7:0] data;
  logic       T_rdy, T_busy, T_done, Tx;

  int n_checks = 0;
  int n_fails  = 0;
  int frames_done = 0;
  int done_pulses = 0;
  int done_before;
  logic [7:0] sb_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .T_start(T_start),
    .data   (data),
    .T_rdy  (T_rdy),
    .T_busy (T_busy),
    .T_done (T_done),
    .Tx     (Tx)
  );

  always #50 clk = ~clk;

  // Count every T_done pulse seen on the falling edge.
  always @(negedge clk) begin
    if (T_done === 1'b1) done_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level during bit k of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Wait for T_rdy, then present the byte for one accept edge. The data bus
  // is scrambled right after the accept edge to prove it is not re-sampled.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    while (T_rdy !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("rdy_timeout", T_rdy, 1);
    data    = b;
    T_start = 1'b1;
    sb_q.push_back(b);
    @(posedge clk);
    #1;
    T_start = 1'b0;
    data    = ~b;
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while (T_rdy !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("idle_timeout", T_rdy, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitDone();
    int guard = 0;
    while (T_done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("done_timeout", T_done, 1);
  endtask

  // Decode one frame whose first low cycle was just observed. Every cycle of
  // every bit is checked, so both the level and its duration are covered.
  task automatic run_frame();
    logic [7:0] exp_b;
    bit aborted = 0;
    checkOutput("sb_empty_at_frame", 32'(sb_q.size() == 0), 0);
    exp_b = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
    for (int c = 1; c <= FRAME_CYC && !aborted; c++) begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        aborted = 1;
      end else begin
        if (c < FRAME_CYC) checkOutput("tx_level", Tx, exp_level(exp_b, c / CPB));
        if (c == FRAME_CYC - 1) checkOutput("done_early", T_done, 0);
        if (c == FRAME_CYC) checkOutput("done_pulse", T_done, 1);
      end
    end
    if (!aborted) frames_done++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && Tx === 1'b0) run_frame();
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    rst     = 1'b0;
    T_start = 1'b0;
    data    = 8'h00;
    #70 rst = 1'b1;

    // Idle after reset: line high, ready, no done pulse.
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_tx", Tx, 1);
      checkOutput("idle_rdy", T_rdy, 1);
      checkOutput("idle_busy", T_busy, 0);
    end
    checkOutput("idle_no_done", done_pulses, 0);

    // Single byte.
    applyStimulus(8'hA5);
    checkOutput("accept_busy", T_busy, 1);
    checkOutput("accept_tx_low", Tx, 0);
    waitIdle();

    // Back-to-back: second request lands in the T_done cycle.
    applyStimulus(8'h00);
    waitDone();
    checkOutput("b2b_rdy_in_done", T_rdy, 1);
    applyStimulus(8'hFF);
    checkOutput("b2b_accepted", T_busy, 1);
    waitIdle();

    // Request while busy is ignored.
    applyStimulus(8'h55);
    repeat (10) @(negedge clk);
    T_start = 1'b1;
    data    = 8'h3C;
    @(negedge clk);
    checkOutput("ignored_busy", T_busy, 1);
    T_start = 1'b0;
    waitIdle();
    repeat (10) @(negedge clk);
    checkOutput("ignored_no_frame", Tx, 1);

    // Reset in the middle of data bit 3 of 0xF0.
    applyStimulus(8'hF0);
    repeat (17) @(negedge clk);
    checkOutput("pre_reset_tx", Tx, 0);
    done_before = done_pulses;
    #10 rst = 1'b0;
    #1;
    checkOutput("rst_async_tx", Tx, 1);
    checkOutput("rst_async_busy", T_busy, 0);
    checkOutput("rst_async_rdy", T_rdy, 1);
    #150 rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_no_done", done_pulses, done_before);
    applyStimulus(8'h81);
    waitIdle();

`ifdef UART_TX_PARITY_EN
    applyStimulus(8'h07);
    waitIdle();
    applyStimulus(8'h03);
    waitIdle();
`endif

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    checkOutput("frame_count", frames_done, EXP_FRAMES);
    checkOutput("done_count", done_pulses, EXP_FRAMES);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
